// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Runs in the PLL output clock domain, directly after the PLL wrapper.
//   It synchronizes the asynchronous PLL lock flag and waits for lock to stay
//   up for a stability window. It then holds the J1 core in reset for a
//   fixed number of cycles and finally releases it. Any loss of lock puts
//   the core back into reset at once and restarts the whole sequence.
//
// Ports:
//   clk            in   PLL output clock (clkOut of the PLL wrapper)
//   reset          in   synchronous, active-high reset
//   isLocked       in   PLL lock flag, asynchronous to clk
//   coreReset      out  registered, active-high reset to the J1 core
//   isRunning      out  registered, 1 exactly while the FSM is in RUN
//   lockLossCount  out  saturating count of lock losses seen while in RUN
//
// Configuration macro:
//   PLL_RESET_LOSS_COUNT_EN
//     Defined:   the lock-loss counter is built.
//     Undefined: no counter logic is built, and lockLossCount is tied to 0.
//                The port list is the same in both builds.
//
// Handshake / debug notes:
//   There is no valid/ready handshake on this block. isLocked is a level
//   input that is sampled every clock. The FSM state is held in the
//   signal 'state' (type stateT), so checkers can bind to it.
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,    // synchronizer depth, >= 2
    parameter int LOCK_STABLE_CYCLES = 1024, // lock stability window, >= 1
    parameter int RESET_HOLD_CYCLES  = 64,   // reset hold after qualification, >= 1
    parameter int CNT_WIDTH          = 16,   // phase counter width
    parameter int LOSS_CNT_WIDTH     = 8     // lock-loss counter width
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      isLocked,
    output logic                      coreReset,
    output logic                      isRunning,
    output logic [LOSS_CNT_WIDTH-1:0] lockLossCount
);

    // -----------------------------------------------------------------------
    // FSM state type
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } stateT;

    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Lock synchronizer
    //
    // syncChain[0] is the capture flop at the asynchronous pin. It is
    // followed by SYNC_STAGES resynchronizing stages. The FSM only sees the
    // last stage (lockSync). Nothing else in this block reads isLocked.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES:0] syncChain;
    logic                 lockSync;

    always_ff @(posedge clk) begin
        if (reset) begin
            syncChain <= '0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-1:0], isLocked};
        end
    end

    assign lockSync = syncChain[SYNC_STAGES];

    // -----------------------------------------------------------------------
    // Next-state logic
    //
    // Lock loss is checked first in every state. This gives it priority
    // over counter completion in the same cycle.
    // -----------------------------------------------------------------------
    stateT                state;
    stateT                nextState;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] nextCnt;

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        case (state)
            WAIT_LOCK: begin
                if (lockSync) begin
                    nextState = STABILIZE;
                    nextCnt   = '0;
                end
            end
            STABILIZE: begin
                if (!lockSync) begin
                    nextState = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    nextState = HOLD;
                    nextCnt   = '0;
                end else begin
                    nextCnt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!lockSync) begin
                    nextState = WAIT_LOCK;
                end else if (cnt == HOLD_LAST) begin
                    nextState = RUN;
                end else begin
                    nextCnt = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lockSync) begin
                    nextState = WAIT_LOCK;
                end
            end
            default: begin
                nextState = WAIT_LOCK;
                nextCnt   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and registered outputs
    //
    // coreReset and isRunning are decoded from nextState and loaded on the
    // same edge as the state register. Each output is driven straight from
    // its own flop, so both are glitch-free. They always stay complementary.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            coreReset <= 1'b1;
            isRunning <= 1'b0;
        end else begin
            state     <= nextState;
            cnt       <= nextCnt;
            coreReset <= (nextState != RUN);
            isRunning <= (nextState == RUN);
        end
    end

    // -----------------------------------------------------------------------
    // Lock-loss counter (optional)
    //
    // Only a RUN -> WAIT_LOCK transition counts as a loss. A drop during
    // STABILIZE or HOLD just restarts qualification and is not counted.
    // The counter saturates at all-ones instead of wrapping to zero.
    // -----------------------------------------------------------------------
`ifdef PLL_RESET_LOSS_COUNT_EN
    logic                      lossEvent;
    logic [LOSS_CNT_WIDTH-1:0] lossCnt;

    assign lossEvent = (state == RUN) && (nextState == WAIT_LOCK);

    always_ff @(posedge clk) begin
        if (reset) begin
            lossCnt <= '0;
        end else if (lossEvent && (lossCnt != {LOSS_CNT_WIDTH{1'b1}})) begin
            lossCnt <= lossCnt + 1'b1;
        end
    end

    assign lockLossCount = lossCnt;
`else
    assign lockLossCount = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Purpose:
//   Self-checking bench for pll_reset_sequencer. It uses small parameters:
//   2 sync stages, a stability window of 8 and a reset hold of 4.
//
// Reference model:
//   The model keeps a history of the lock samples. A sample is 1 when
//   isLocked was high and reset was low at that edge. The rules it applies:
//     - A lock change shows up at the FSM LAT = SYNC_STAGES + 1 edges
//       after it is sampled.
//     - The core is released once WIN = stable + hold + 1 consecutive
//       good samples have been seen.
//     - A reset edge clears the samples still in flight in the
//       synchronizer.
//   The model counts a loss on every released -> not-released change
//   that is not caused by reset. This count saturates.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int SYNC_STAGES  = 2;
    localparam int LOCK_STABLE  = 8;
    localparam int RESET_HOLD   = 4;
    localparam int CNT_WIDTH    = 16;
    localparam int LOSS_W       = 8;

    localparam int LAT   = SYNC_STAGES + 1;
    localparam int WIN   = LOCK_STABLE + RESET_HOLD + 1;
    localparam int DEPTH = LAT + WIN;
    localparam int REL_LATENCY  = SYNC_STAGES + LOCK_STABLE + RESET_HOLD + 1; // 15
    localparam int LOSS_LATENCY = SYNC_STAGES + 1;                            // 3
    localparam int LOSS_MAX     = (1 << LOSS_W) - 1;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              isLocked = 1'b0;
    logic              coreReset;
    logic              isRunning;
    logic [LOSS_W-1:0] lockLossCount;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .SYNC_STAGES       (SYNC_STAGES),
        .LOCK_STABLE_CYCLES(LOCK_STABLE),
        .RESET_HOLD_CYCLES (RESET_HOLD),
        .CNT_WIDTH         (CNT_WIDTH),
        .LOSS_CNT_WIDTH    (LOSS_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .isLocked     (isLocked),
        .coreReset    (coreReset),
        .isRunning    (isRunning),
        .lockLossCount(lockLossCount)
    );

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DEPTH-1:0]  hist = '0;
    logic              expRel = 1'b0;
    logic [LOSS_W-1:0] expLoss = '0;
    logic              modelValid = 1'b0;

    always @(posedge clk) begin
        automatic logic [DEPTH-1:0] h;
        automatic logic             rel;
        h = {hist[DEPTH-2:0], (isLocked && !reset)};
        if (reset) begin
            for (int k = 1; k <= LAT; k++) h[k] = 1'b0;
        end
        rel = 1'b1;
        for (int k = LAT; k < DEPTH; k++) rel = rel & h[k];
        hist <= h;
        expRel <= rel;
        if (reset) begin
            expLoss <= '0;
            modelValid <= 1'b1;
        end else if (expRel && !rel && (int'(expLoss) != LOSS_MAX)) begin
            expLoss <= expLoss + 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (modelValid) begin
            check("coreReset", 32'(coreReset), 32'(!expRel));
            check("isRunning", 32'(isRunning), 32'(expRel));
`ifdef PLL_RESET_LOSS_COUNT_EN
            check("lockLossCount", 32'(lockLossCount), 32'(expLoss));
`else
            check("lockLossCount", 32'(lockLossCount), 32'd0);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic l, input logic r);
        @(negedge clk);
        #1;
        isLocked = l;
        reset    = r;
    endtask

    // Drives isLocked high from edge 0 on. The only exception is a single
    // low sample at edge glitchAt (use -1 for no glitch). It reports the
    // edge after which isRunning first went high, or -1 if it never did.
    task automatic runPattern(input int glitchAt, input int span, output int relEdge);
        relEdge = -1;
        for (int k = 0; k <= span; k++) begin
            @(negedge clk);
            if (k > 0 && isRunning && relEdge < 0) relEdge = k - 1;
            #1;
            isLocked = (k != glitchAt);
            reset    = 1'b0;
        end
    endtask

    // Drops isLocked from edge 0 on. It reports the edge after which
    // coreReset rose, or -1 if it never did.
    task automatic runLoss(input int span, output int riseEdge);
        riseEdge = -1;
        for (int k = 0; k <= span; k++) begin
            @(negedge clk);
            if (k > 0 && coreReset && riseEdge < 0) riseEdge = k - 1;
            #1;
            isLocked = 1'b0;
            reset    = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int relEdge;
        int riseEdge;
        int hi;
        int lo;
        logic [LOSS_W-1:0] lossBefore;

        // Power-up: 3 reset cycles with the PLL unlocked, then released.
        repeat (3) tick(1'b0, 1'b1);
        repeat (10) begin
            tick(1'b0, 1'b0);
            check("pwrState", 32'(dut.state), 32'd0);
            check("pwrCoreReset", 32'(coreReset), 32'd1);
        end

        // Clean lock.
        runPattern(-1, 25, relEdge);
        check("cleanRelease", 32'(relEdge), 32'(REL_LATENCY));

        // Run for 10 cycles, then lose lock.
        repeat (10) tick(1'b1, 1'b0);
        lossBefore = lockLossCount;
        runLoss(8, riseEdge);
        check("lossRise", 32'(riseEdge), 32'(LOSS_LATENCY));
`ifdef PLL_RESET_LOSS_COUNT_EN
        check("lossCount1", 32'(lockLossCount), 32'(lossBefore) + 32'd1);
`else
        check("lossCount1", 32'(lockLossCount), 32'(lossBefore));
`endif

        // Re-lock gives a fresh release.
        runPattern(-1, 25, relEdge);
        check("relockRelease", 32'(relEdge), 32'(REL_LATENCY));

        // Glitch during STABILIZE: a one-sample drop at edge 6.
        runLoss(8, riseEdge);
        runPattern(6, 35, relEdge);
        check("glitchRelease", 32'(relEdge), 32'(7 + REL_LATENCY));

        // A glitch during HOLD restarts the sequence too.
        runLoss(8, riseEdge);
        runPattern(12, 40, relEdge);
        check("holdGlitchRelease", 32'(relEdge), 32'(13 + REL_LATENCY));

        // Saturation: 300 losses while in RUN.
        for (int i = 0; i < 300; i++) begin
            repeat (REL_LATENCY + 2) tick(1'b1, 1'b0);
            repeat (4) tick(1'b0, 1'b0);
        end
        repeat (8) tick(1'b0, 1'b0);
`ifdef PLL_RESET_LOSS_COUNT_EN
        check("lossSaturated", 32'(lockLossCount), 32'(LOSS_MAX));
`else
        check("lossSaturated", 32'(lockLossCount), 32'd0);
`endif

        // Reach RUN, then pulse reset.
        repeat (REL_LATENCY + 5) tick(1'b1, 1'b0);
        check("preResetRun", 32'(isRunning), 32'd1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        check("rstCoreReset", 32'(coreReset), 32'd1);
        check("rstLossCount", 32'(lockLossCount), 32'd0);
        // Releasing reset with the lock already high: the same latency as a
        // fresh lock, counted from the first edge with reset low.
        relEdge = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (isRunning && relEdge < 0) relEdge = k;
        end
        check("postResetRelease", 32'(relEdge), 32'(REL_LATENCY));

        // Randomized bursts with occasional resets.
        for (int i = 0; i < 200; i++) begin
            hi = $urandom_range(1, 30);
            lo = $urandom_range(1, 6);
            repeat (hi) tick(1'b1, ($urandom_range(0, 149) == 0));
            repeat (lo) tick(1'b0, 1'b0);
        end
        repeat (5) tick(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
